// File: rtl/noc_flit_injector.sv
// Purpose : local packet injector; allocates a downstream VC round-robin, emits head/body/tail flits.
// Latency : descriptor accept -> head valid in 2 cycles minimum; body flits are zero-latency pass-through.
// Backpres: head is held stable until out_ready; body backpressure goes straight to data_ready; VC_ALLOC stalls with no free VC.
// Option  : define NOC_INJ_PERF_EN to add the perf_flits / perf_pkts / perf_stall counters.
module noc_flit_injector #(
    parameter  int FLIT_WIDTH = 32,
    parameter  int VC_NUM     = 4,
    parameter  int DEST_W     = 8,
    parameter  int LEN_W      = 8,
    localparam int VC_W       = $clog2(VC_NUM),
    localparam int PAYLOAD_W  = FLIT_WIDTH - 2 - VC_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [DEST_W-1:0]     pkt_dest,
    input  logic [LEN_W-1:0]      pkt_len,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [PAYLOAD_W-1:0]  data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    input  logic [VC_NUM-1:0]     out_vc_ready,
    output logic                  busy
`ifdef NOC_INJ_PERF_EN
    ,
    output logic [31:0]           perf_flits,
    output logic [31:0]           perf_pkts,
    output logic [31:0]           perf_stall
`endif
);

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_VC_ALLOC, S_HEAD, S_BODY} state_t;

    typedef struct packed {
        logic [1:0]           ftype;
        logic [VC_W-1:0]      vc;
        logic [PAYLOAD_W-1:0] dat;
    } flit_t;

    // The head must carry {len, dest}, and the VC field must address every VC exactly.
    if (PAYLOAD_W < DEST_W + LEN_W) begin : g_bad_payload_w
        $error("noc_flit_injector: payload field too narrow for {pkt_len, pkt_dest}");
    end
    if (VC_NUM < 2 || (1 << VC_W) != VC_NUM) begin : g_bad_vc_num
        $error("noc_flit_injector: VC_NUM must be a power of two and at least 2");
    end

    state_t                state;
    logic [DEST_W-1:0]     dest_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      remaining;
    logic [VC_W-1:0]       vc_sel;
    logic [VC_W-1:0]       rr_ptr;
    logic                  head_vld;
    flit_t                 head_flit;
    flit_t                 body_flit;
    logic [VC_W-1:0]       alloc_vc;
    logic [VC_W-1:0]       scan_vc;
    logic                  alloc_found;
    logic [PAYLOAD_W-1:0]  head_data;

    // Round-robin search: first free VC at or after rr_ptr, wrapping through the power-of-two index space.
    always_comb begin
        alloc_found = 1'b0;
        alloc_vc    = '0;
        scan_vc     = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            scan_vc = rr_ptr + VC_W'(i);
            if (!alloc_found && out_vc_ready[scan_vc]) begin
                alloc_found = 1'b1;
                alloc_vc    = scan_vc;
            end
        end
    end

    // Head data field: zero-padded {len, dest} from the captured descriptor.
    always_comb begin
        head_data                        = '0;
        head_data[DEST_W+LEN_W-1:0]      = {len_q, dest_q};
    end

    // Body flits pass payload straight through; the last one is typed TAIL.
    always_comb begin
        body_flit.ftype = (remaining == LEN_W'(1)) ? T_TAIL : T_BODY;
        body_flit.vc    = vc_sel;
        body_flit.dat   = data;
    end

    assign out_valid  = head_vld | ((state == S_BODY) & data_valid);
    assign out_flit   = (state == S_BODY) ? body_flit : head_flit;
    assign data_ready = (state == S_BODY) & out_ready;

    // Packet sequencer: descriptor capture, VC allocation, head issue, body countdown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pkt_ready <= 1'b0;
            busy      <= 1'b0;
            dest_q    <= '0;
            len_q     <= '0;
            remaining <= '0;
            vc_sel    <= '0;
            rr_ptr    <= '0;
            head_vld  <= 1'b0;
            head_flit <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    pkt_ready <= 1'b1;
                    if (pkt_valid && pkt_ready) begin
                        dest_q    <= pkt_dest;
                        len_q     <= pkt_len;
                        pkt_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_VC_ALLOC;
                    end
                end
                S_VC_ALLOC: begin
                    if (alloc_found) begin
                        vc_sel          <= alloc_vc;
                        rr_ptr          <= alloc_vc + VC_W'(1);
                        head_flit.ftype <= (len_q == '0) ? T_SINGLE : T_HEAD;
                        head_flit.vc    <= alloc_vc;
                        head_flit.dat   <= head_data;
                        head_vld        <= 1'b1;
                        state           <= S_HEAD;
                    end
                end
                S_HEAD: begin
                    if (out_ready) begin
                        head_vld  <= 1'b0;
                        head_flit <= '0;
                        if (len_q == '0) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            pkt_ready <= 1'b1;
                        end else begin
                            remaining <= len_q;
                            state     <= S_BODY;
                        end
                    end
                end
                S_BODY: begin
                    if (data_valid && out_ready) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            pkt_ready <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef NOC_INJ_PERF_EN
    // Free-running wrap-around counters: flits sent, packets started, and stall cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_flits <= '0;
            perf_pkts  <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid && out_ready) perf_flits <= perf_flits + 32'd1;
            if (head_vld && out_ready)  perf_pkts  <= perf_pkts + 32'd1;
            if ((state == S_VC_ALLOC && !alloc_found) || (out_valid && !out_ready))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_flit_injector.sv
// Bench for noc_flit_injector: randomized packets, queue-based flit scoreboard with an independent monitor.
// Expected flits are built from the flit format rules and a round-robin VC model.
// Stimulus drives #1 after posedge; monitor samples at negedge.
module tb_noc_flit_injector;
    localparam int FW  = 32;
    localparam int VCN = 4;
    localparam int DW  = 8;
    localparam int LW  = 8;
    localparam int VW  = 2;
    localparam int PW  = FW - 2 - VW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pkt_valid, pkt_ready;
    logic [DW-1:0] pkt_dest;
    logic [LW-1:0] pkt_len;
    logic          data_valid, data_ready;
    logic [PW-1:0] data;
    logic          out_valid, out_ready;
    logic [FW-1:0] out_flit;
    logic [VCN-1:0] out_vc_ready;
    logic          busy;
`ifdef NOC_INJ_PERF_EN
    logic [31:0]   perf_flits, perf_pkts, perf_stall;
`endif

    noc_flit_injector dut (
        .clk(clk), .rst_n(rst_n),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dest(pkt_dest), .pkt_len(pkt_len),
        .data_valid(data_valid), .data_ready(data_ready), .data(data),
        .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit), .out_vc_ready(out_vc_ready),
        .busy(busy)
`ifdef NOC_INJ_PERF_EN
        , .perf_flits(perf_flits), .perf_pkts(perf_pkts), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [FW-1:0] exp_q[$];
    logic [PW-1:0] pay_q[$];
    int m_rr = 0;
    int or_pct = 100;
    int dv_pct = 100;
    int n_xfer = 0;
    int n_data = 0;
    int exp_data = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [FW-1:0] mk_flit(input int typ, input int vc, input longint dat);
        return FW'((longint'(typ) << (FW - 2)) + (longint'(vc) << PW) + dat);
    endfunction

    // Monitor: pops the scoreboard on every accepted flit, and checks stability while stalled.
    initial begin
        logic          prev_stall;
        logic [FW-1:0] prev_flit;
        logic [FW-1:0] e;
        prev_stall = 1'b0;
        prev_flit  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk(out_valid && out_flit == prev_flit, "hold_stable", {31'd0, out_valid, out_flit}, {31'd0, 1'b1, prev_flit});
                if (out_valid && out_ready) begin
                    n_xfer++;
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_flit", out_flit, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(out_flit === e, "flit", out_flit, e);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_flit  = out_flit;
            end
        end
    end

    // Downstream ready, randomized by or_pct.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(99) < or_pct);
        end
    end

    // Payload source: presents pay_q front, holds it until accepted.
    initial begin
        bit took;
        data_valid = 1'b0;
        data = '0;
        forever begin
            @(negedge clk);
            took = data_valid && data_ready && rst_n;
            @(posedge clk); #1;
            if (!rst_n) begin
                data_valid = 1'b0;
            end else begin
                if (took) begin
                    n_data++;
                    if (pay_q.size() > 0) void'(pay_q.pop_front());
                end
                if (took || !data_valid) begin
                    if (pay_q.size() > 0 && $urandom_range(99) < dv_pct) begin
                        data_valid = 1'b1;
                        data = pay_q[0];
                    end else begin
                        data_valid = 1'b0;
                        data = PW'($urandom);
                    end
                end
            end
        end
    end

    // Model the packet, queue its flits and payload, then hand the descriptor over.
    task automatic issue_pkt(input int dest, input int len, input logic [VCN-1:0] vcr, input bit stall_first);
        int vc;
        bit acc;
        logic [PW-1:0] w;
        vc = -1;
        for (int i = 0; i < VCN; i++)
            if (vc < 0 && vcr[(m_rr + i) % VCN]) vc = (m_rr + i) % VCN;
        m_rr = (vc + 1) % VCN;
        exp_q.push_back(mk_flit(len == 0 ? 3 : 1, vc, longint'(len) * 256 + dest));
        for (int k = 1; k <= len; k++) begin
            w = PW'($urandom);
            pay_q.push_back(w);
            exp_q.push_back(mk_flit(k == len ? 2 : 0, vc, longint'(w)));
        end
        exp_data += len;
        out_vc_ready = stall_first ? '0 : vcr;
        pkt_dest  = DW'(dest);
        pkt_len   = LW'(len);
        pkt_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = pkt_ready;
            @(posedge clk); #1;
        end
        pkt_valid = 1'b0;
        if (!acc) chk(1'b0, "pkt_accept_timeout", 0, 1);
    endtask

    // Wait for the scoreboard to drain; scramble vc_ready once the head is out.
    task automatic finish_pkt(input int len);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 4000 && !done; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
            @(posedge clk); #1;
            if (exp_q.size() < len + 1) out_vc_ready = VCN'($urandom);
        end
        if (!done) begin
            chk(1'b0, "pkt_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
        chk(pay_q.size() == 0, "payload_consumed", pay_q.size(), 0);
        chk(busy == 1'b0, "busy_after", busy, 0);
        chk(pkt_ready == 1'b1, "ready_after", pkt_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk(pkt_ready == 1'b0,  {tag, "_pkt_ready"}, pkt_ready, 0);
        chk(data_ready == 1'b0, {tag, "_data_ready"}, data_ready, 0);
        chk(out_valid == 1'b0,  {tag, "_out_valid"}, out_valid, 0);
        chk(out_flit == '0,     {tag, "_out_flit"}, out_flit, 0);
        chk(busy == 1'b0,       {tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;
        int hv;
        bit seen;
        int base;
        logic [VCN-1:0] vr;
`ifdef NOC_INJ_PERF_EN
        logic [31:0] ps0;
`endif
        pkt_valid = 1'b0; pkt_dest = '0; pkt_len = '0; out_vc_ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Multi-flit packet on vc 0, then the pointer moves on to vc 1, then a single-flit wraps to vc 0.
        issue_pkt('h12, 3, 4'b1111, 1'b0); finish_pkt(3);
        issue_pkt('h33, 1, 4'b1111, 1'b0); finish_pkt(1);
        issue_pkt('h05, 0, 4'b0001, 1'b0); finish_pkt(0);

        // No VC free for 10 cycles, then only vc 2.
`ifdef NOC_INJ_PERF_EN
        ps0 = perf_stall;
`endif
        issue_pkt('h40, 2, 4'b0100, 1'b1);
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) quiet = 1'b0;
            @(posedge clk); #1;
        end
        chk(quiet, "stall_quiet", !quiet, 0);
        out_vc_ready = 4'b0100;
        finish_pkt(2);
`ifdef NOC_INJ_PERF_EN
        chk(perf_stall - ps0 == 32'd10, "perf_stall", perf_stall - ps0, 10);
`endif

        // Head held by downstream for several cycles.
        or_pct = 0;
        issue_pkt('h21, 2, 4'b1111, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        hv = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid && !out_ready) hv++;
            @(negedge clk);
        end
        chk(hv == 5, "head_hold_cycles", hv, 5);
        or_pct = 100;
        @(posedge clk); #1;
        finish_pkt(2);

        // Maximum length with ragged payload and downstream.
        dv_pct = 50; or_pct = 70;
        issue_pkt('h7f, 255, 4'b1011, 1'b0); finish_pkt(255);

        // Random packets.
        for (int p = 0; p < 20; p++) begin
            dv_pct = $urandom_range(30, 100);
            or_pct = $urandom_range(30, 100);
            vr = VCN'($urandom_range(1, 15));
            issue_pkt($urandom_range(0, 255), $urandom_range(0, 12), vr, 1'b0);
            finish_pkt(0);
        end

        // Reset after the second body flit of a len=4 packet.
        dv_pct = 100; or_pct = 100;
        issue_pkt('h44, 4, 4'b1111, 1'b0);
        base = n_xfer - 0;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            if (n_xfer >= base + 3) seen = 1'b1;
        end
        chk(seen, "pre_reset_flits", n_xfer - base, 3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_vals("midreset");
        @(posedge clk); #1;
        exp_q.delete();
        pay_q.delete();
        m_rr = 0;
        exp_data = n_data;
        rst_n = 1'b1;
        issue_pkt('h09, 2, 4'b1111, 1'b0); finish_pkt(2);

        chk(n_data == exp_data, "data_xfers", n_data, exp_data);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/noc_flit_injector.md
Name: noc_flit_injector

Overview:
- Local-side packet injector that drives the sender modport of Noc_flit_interface (valid, ready, flit, vc_ready) toward a router input port.
- Accepts one packet descriptor plus a stream of payload words from the processing element.
- Allocates a free downstream VC round-robin and serializes the packet into head, body and tail flits.
- Holds the allocated VC for the packet's whole lifetime.

Parameters:
- FLIT_WIDTH, 32, total flit width in bits.
- VC_NUM, 4, number of virtual channels. Must be a power of two, at least 2.
- DEST_W, 8, destination node ID width.
- LEN_W, 8, payload-flit count width (0 to 2^LEN_W-1 payload flits).
- PAYLOAD_W, FLIT_WIDTH-2-$clog2(VC_NUM), derived data field width; localparam, not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- pkt_valid  in  1  descriptor valid
- pkt_ready  out  1  descriptor accepted when valid&&ready
- pkt_dest  in  DEST_W  destination node
- pkt_len  in  LEN_W  number of payload flits following the head
- data_valid  in  1  payload word valid
- data_ready  out  1  payload word accepted
- data  in  PAYLOAD_W  payload word
- out_valid  out  1  flit valid (sender_if.valid)
- out_ready  in  1  downstream accepts flit (sender_if.ready)
- out_flit  out  FLIT_WIDTH  flit (sender_if.flit)
- out_vc_ready  in  VC_NUM  per-VC free indication (sender_if.vc_ready)
- busy  out  1  packet in flight

Behaviour:
- One clock: clk. Reset is synchronous, active-low: rst_n, sampled on the rising edge of clk.
- Flit format:
  - [FLIT_WIDTH-1:FLIT_WIDTH-2] type: BODY=00, HEAD=01, TAIL=10, SINGLE=11.
  - Next $clog2(VC_NUM) bits: VC id.
  - Low PAYLOAD_W bits: data.
  - Head/single data field = {zero-pad, pkt_len, pkt_dest}. Requires PAYLOAD_W >= DEST_W+LEN_W; elaboration error otherwise.
- Reset values: pkt_ready=0, data_ready=0, out_valid=0, out_flit=0, busy=0, RR pointer=0, state=IDLE. Reset mid-packet aborts the packet silently, with no tail emitted.
- FSM:
  - IDLE: pkt_ready=1. On pkt_valid, capture dest/len and go to VC_ALLOC.
  - VC_ALLOC: pick the first set bit of out_vc_ready at or after the RR pointer, wrapping.
    - If none is set, stay; this is the stall case.
    - Otherwise latch vc_sel, set RR pointer = vc_sel+1 mod VC_NUM, and go to HEAD.
  - HEAD: out_valid=1 with the head flit (type SINGLE if len==0). On out_ready: if len==0 go to IDLE, else go to BODY with remaining=len.
  - BODY: out_flit is a combinational pass of data with type TAIL if remaining==1, else BODY. out_valid=data_valid, data_ready=out_ready.
    - On a data_valid&&out_ready transfer, decrement remaining.
    - On the transfer with remaining==1, go to IDLE.
- Latency: descriptor accept to head valid is 2 cycles minimum (IDLE→VC_ALLOC→HEAD). Body flits are zero-latency pass-through.
- Handshake: while out_valid=1 and out_ready=0, out_flit must stay stable. BODY satisfies this as long as the upstream holds data stable while data_valid=1.
- vc_ready is sampled only in VC_ALLOC. A deassert after allocation does not affect the packet in flight.
- busy=1 in every state except IDLE.
- Back-to-back packets: a new descriptor can be accepted the cycle after the tail transfer. There is no bubble beyond IDLE's single cycle.

Optional Feature:
- Macro: NOC_INJ_PERF_EN.
- When defined, adds three outputs:
  - perf_flits (32b): counts every out_valid&&out_ready.
  - perf_pkts (32b): counts head/single transfers.
  - perf_stall (32b): counts cycles in VC_ALLOC with no free VC, plus cycles with out_valid&&!out_ready.
  - All three reset to 0 and wrap at 2^32.
- When undefined, these ports and their logic are absent.

Test Plan:
- Descriptor dest=0x05, len=0, out_vc_ready=4'b0001, out_ready=1 → one flit: type 11, vc 0, data 0x0005 (len 0x00, dest 0x05). busy=0 two cycles after the transfer.
- dest=0x12, len=3, payload A,B,C, all VCs ready → flits HEAD/BODY/BODY/TAIL on vc 0 with data {0x03,0x12}, A, B, C. The next packet goes to vc 1.
- out_vc_ready=0 for 10 cycles after a descriptor, then 4'b0100 → out_valid stays 0 for those 10 cycles, then the head is sent on vc 2. With NOC_INJ_PERF_EN, perf_stall=10.
- Head valid with out_ready=0 for 5 cycles → out_flit stable across all 5 cycles, transfer on the 6th, no duplicate head.
- len=255 with data_valid toggling randomly → exactly 255 body flits, the last one typed TAIL, no extra data_ready pulses.
- Drive rst_n=0 after the second body flit of a len=4 packet → all outputs return to reset values, and the next packet starts cleanly with a head on vc 0.
